// File: rtl/dcache_direct_wb.sv
// rtl/dcache_direct_wb.sv - direct-mapped write-back write-allocate data cache
module dcache_direct_wb #(
  parameter int ADDR_W  = 30,
  parameter int INDEX_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic [31:0]       proc_rdata,
  output logic              proc_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready
);

  localparam int TAG_W   = ADDR_W - INDEX_W - 2;
  localparam int NUM_BLK = 1 << INDEX_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WBACK = 2'd1;
  localparam logic [1:0] ALLOC = 2'd2;

  logic [1:0] state, state_nxt;

  logic [NUM_BLK-1:0] valid;
  logic [NUM_BLK-1:0] dirty;
  logic [TAG_W-1:0]   tag_mem  [NUM_BLK];
  logic [127:0]       data_mem [NUM_BLK];

  logic [1:0]         off;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               req;
  logic               hit;
  logic               victim_dirty;

  assign off = proc_addr[1:0];
  assign idx = proc_addr[INDEX_W+1:2];
  assign tag = proc_addr[ADDR_W-1:INDEX_W+2];

  assign req          = proc_read | proc_write;
  assign hit          = req & valid[idx] & (tag_mem[idx] == tag);
  assign victim_dirty = valid[idx] & dirty[idx];

  // Load data is always the addressed word of the indexed block; it is only meaningful on a read hit.
  assign proc_rdata = data_mem[idx][{off, 5'b0} +: 32];

  // Next-state selection: a miss goes through write-back only when the victim holds modified data.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          state_nxt = victim_dirty ? WBACK : ALLOC;
        end
      end
      WBACK: begin
        if (mem_ready) begin
          state_nxt = ALLOC;
        end
      end
      ALLOC: begin
        if (mem_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Moore memory-side outputs and the processor stall; stall is masked while reset is held so an abandoned request does not freeze the core.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    proc_stall = 1'b0;
    case (state)
      IDLE: begin
        proc_stall = req & ~hit;
      end
      WBACK: begin
        mem_write  = 1'b1;
        mem_addr   = {tag_mem[idx], idx};
        mem_wdata  = data_mem[idx];
        proc_stall = 1'b1;
      end
      ALLOC: begin
        mem_read   = 1'b1;
        mem_addr   = {tag, idx};
        proc_stall = 1'b1;
      end
      default: begin
        proc_stall = 1'b0;
      end
    endcase
    if (!rst_n) begin
      proc_stall = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Line storage: store hits merge one word and mark dirty; a completed refill installs a clean block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
      for (int i = 0; i < NUM_BLK; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (state == IDLE && proc_write && hit) begin
        data_mem[idx][{off, 5'b0} +: 32] <= proc_wdata;
        dirty[idx]                       <= 1'b1;
      end else if (state == ALLOC && mem_ready) begin
        data_mem[idx] <= mem_rdata;
        tag_mem[idx]  <= tag;
        valid[idx]    <= 1'b1;
        dirty[idx]    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_direct_wb.sv
// tb/tb_dcache_direct_wb.sv - scoreboard bench for dcache_direct_wb
module tb_dcache_direct_wb;

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  dcache_direct_wb #(.ADDR_W(30), .INDEX_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_pass   = 0;
  int           lat_r    = 1;
  int           lat_w    = 1;
  int           mcnt     = 0;
  logic [127:0] bm    [256];
  logic [31:0]  ref_w [1024];
  logic [31:0]  exp_q [$];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_blk(input logic [27:0] b);
    logic [9:0] base;
    base = {b[7:0], 2'b00};
    return {ref_w[base + 10'd3], ref_w[base + 10'd2], ref_w[base + 10'd1], ref_w[base]};
  endfunction

  // Block-wide memory model: answers after lat_r / lat_w request cycles with a one-cycle mem_ready.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mem_ready = 1'b0;
        mcnt      = 0;
      end else begin
        #1;
        if (mem_ready) begin
          mem_ready = 1'b0;
          mcnt      = 0;
        end
        if (mem_read || mem_write) begin
          mcnt++;
          if (mcnt == (mem_write ? lat_w : lat_r)) begin
            if (mem_write) bm[mem_addr[7:0]] = mem_wdata;
            else           mem_rdata = bm[mem_addr[7:0]];
            mem_ready = 1'b1;
          end
        end
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d,
                        output int stalls, output int rdc, output int wrc,
                        output logic [27:0] ra, output logic [27:0] wa, output logic [127:0] wd);
    logic        both;
    logic        unstable;
    logic [31:0] exp;
    stalls = 0; rdc = 0; wrc = 0; ra = '0; wa = '0; wd = '0;
    both = 1'b0; unstable = 1'b0;
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = d;
    if (wr) ref_w[a[9:0]] = d;
    else    exp_q.push_back(ref_w[a[9:0]]);
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) both = 1'b1;
      if (mem_read) begin
        if (rdc > 0 && mem_addr !== ra) unstable = 1'b1;
        ra = mem_addr;
        rdc++;
      end
      if (mem_write) begin
        if (wrc > 0 && (mem_addr !== wa || mem_wdata !== wd)) unstable = 1'b1;
        wa = mem_addr;
        wd = mem_wdata;
        wrc++;
      end
      if (!proc_stall) begin
        if (!wr && exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check_val("rdata", 128'(proc_rdata), 128'(exp));
        end
        break;
      end
      stalls++;
      if (stalls > 300) begin
        check_val("timeout", 128'(1), 128'(0));
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    check_val("mem_rd_wr_both", 128'(both), 128'(0));
    check_val("mem_req_stable", 128'(unstable), 128'(0));
    if (wrc > 0) check_val("wb_block", wd, ref_blk(wa));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int           st, rc, wc;
    logic [27:0]  ra, wa;
    logic [127:0] wd;

    for (int i = 0; i < 256; i++) begin
      bm[i] = {32'(i*4+3), 32'(i*4+2), 32'(i*4+1), 32'(i*4)};
    end
    for (int j = 0; j < 1024; j++) ref_w[j] = 32'(j);
    bm[1] = {32'h33, 32'h22, 32'h11, 32'h00};
    ref_w[4] = 32'h00; ref_w[5] = 32'h11; ref_w[6] = 32'h22; ref_w[7] = 32'h33;

    rst_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
    #1;
    check_val("rst_stall", 128'(proc_stall), 128'(0));
    check_val("rst_mem_read", 128'(mem_read), 128'(0));
    check_val("rst_mem_write", 128'(mem_write), 128'(0));
    check_val("rst_mem_addr", 128'(mem_addr), 128'(0));
    check_val("rst_mem_wdata", mem_wdata, 128'(0));
    check_val("rst_rdata", 128'(proc_rdata), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // clean miss, L=3
    lat_r = 3;
    access(1'b1, 1'b0, 30'h5, 32'h0, st, rc, wc, ra, wa, wd);
    check_val("miss_stall", 128'(st), 128'(4));
    check_val("miss_rd_cycles", 128'(rc), 128'(3));
    check_val("miss_rd_addr", 128'(ra), 128'(1));
    check_val("miss_wr_cycles", 128'(wc), 128'(0));

    // read hit
    access(1'b1, 1'b0, 30'h6, 32'h0, st, rc, wc, ra, wa, wd);
    check_val("hit_stall", 128'(st), 128'(0));
    check_val("hit_rd_cycles", 128'(rc), 128'(0));

    // write hit
    access(1'b0, 1'b1, 30'h4, 32'hDEADBEEF, st, rc, wc, ra, wa, wd);
    check_val("whit_stall", 128'(st), 128'(0));
    check_val("whit_traffic", 128'(rc + wc), 128'(0));

    // dirty conflict miss: write-back then refill
    lat_w = 2; lat_r = 3;
    access(1'b1, 1'b0, 30'h24, 32'h0, st, rc, wc, ra, wa, wd);
    check_val("dmiss_stall", 128'(st), 128'(6));
    check_val("dmiss_wr_cycles", 128'(wc), 128'(2));
    check_val("dmiss_wr_addr", 128'(wa), 128'(1));
    check_val("dmiss_wdata", wd, {32'h33, 32'h22, 32'h11, 32'hDEADBEEF});
    check_val("dmiss_rd_cycles", 128'(rc), 128'(3));
    check_val("dmiss_rd_addr", 128'(ra), 128'(9));

    // write miss to invalid line: refill only, then store
    lat_r = 2;
    access(1'b0, 1'b1, 30'h10, 32'hA5A5A5A5, st, rc, wc, ra, wa, wd);
    check_val("wmiss_stall", 128'(st), 128'(3));
    check_val("wmiss_rd_cycles", 128'(rc), 128'(2));
    check_val("wmiss_wr_cycles", 128'(wc), 128'(0));
    access(1'b1, 1'b0, 30'h11, 32'h0, st, rc, wc, ra, wa, wd);
    check_val("wmiss_neighbor_hit", 128'(st), 128'(0));
    lat_w = 1; lat_r = 1;
    access(1'b1, 1'b0, 30'h30, 32'h0, st, rc, wc, ra, wa, wd);
    check_val("wb2_stall", 128'(st), 128'(3));
    check_val("wb2_wr_addr", 128'(wa), 128'(4));
    check_val("wb2_word0", 128'(wd[31:0]), 128'(32'hA5A5A5A5));

    // reset asserted during ALLOC
    lat_r = 10;
    proc_read = 1'b1; proc_addr = 30'h44;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_read) break;
    end
    check_val("alloc_reached", 128'(mem_read), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check_val("rstmid_mem_read", 128'(mem_read), 128'(0));
    check_val("rstmid_stall", 128'(proc_stall), 128'(0));
    check_val("rstmid_mem_write", 128'(mem_write), 128'(0));
    proc_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    lat_r = 1;
    access(1'b1, 1'b0, 30'h24, 32'h0, st, rc, wc, ra, wa, wd);
    check_val("post_rst_miss_stall", 128'(st), 128'(2));
    check_val("post_rst_rd_cycles", 128'(rc), 128'(1));
    check_val("post_rst_wr_cycles", 128'(wc), 128'(0));

    // long write-back: mem_ready held off for 20 cycles
    access(1'b0, 1'b1, 30'h24, 32'h12345678, st, rc, wc, ra, wa, wd);
    check_val("whit2_stall", 128'(st), 128'(0));
    lat_w = 21; lat_r = 1;
    access(1'b1, 1'b0, 30'h4, 32'h0, st, rc, wc, ra, wa, wd);
    check_val("slow_wb_stall", 128'(st), 128'(23));
    check_val("slow_wb_wr_cycles", 128'(wc), 128'(21));
    check_val("slow_wb_wr_addr", 128'(wa), 128'(9));
    check_val("slow_wb_rd_cycles", 128'(rc), 128'(1));
    check_val("slow_wb_rd_addr", 128'(ra), 128'(1));

    check_val("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_direct_wb.md
Name: dcache_direct_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the single-cycle MIPS data-memory port and a slower block-wide main memory.
- Hits complete in the same cycle with no stall.
- Misses assert proc_stall until the block is written back if dirty, refilled, and the access then hits.
- Enables the core to run against multi-cycle data memory.

Parameters:
- ADDR_W, 30, processor word-address width; tag width = ADDR_W-INDEX_W-2.
- INDEX_W, 3, index bits; 2**INDEX_W blocks of 4 x 32-bit words (default 8 blocks = 32 words).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- proc_read  input  1  processor load request, level, held while proc_stall=1
- proc_write  input  1  processor store request, level, held while proc_stall=1
- proc_addr  input  ADDR_W  word address: [1:0] word offset, [INDEX_W+1:2] index, [ADDR_W-1:INDEX_W+2] tag
- proc_wdata  input  32  store data
- proc_rdata  output  32  load data, combinational from the indexed block/offset
- proc_stall  output  1  1 = access not complete; the core must freeze PC and hold the request
- mem_read  output  1  block refill request
- mem_write  output  1  block write-back request
- mem_addr  output  ADDR_W-2  block address {tag,index}
- mem_wdata  output  128  write-back block; word0 in [31:0]
- mem_rdata  input  128  refill block; word0 in [31:0]
- mem_ready  input  1  one-cycle pulse: the current memory request is complete; mem_rdata is valid in the same cycle

Behaviour:
- Storage per block: valid, dirty, tag, 128-bit data.
- Reset (async, rst_n=0) clears:
  - all valid, dirty, tag and data to 0;
  - state=IDLE; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0;
  - proc_stall=0 (no request); proc_rdata=0.
- FSM states: IDLE, WBACK, ALLOC.
- IDLE:
  - hit = (proc_read|proc_write) & valid[idx] & tag[idx]==addr tag.
  - Read hit: proc_stall=0, proc_rdata = data[idx][off*32+:32] in the same cycle.
  - Write hit: proc_stall=0; at the clock edge, write the word into data[idx] and set dirty[idx]=1.
  - Miss (request & !hit): proc_stall=1 combinationally.
    - Next state is WBACK if valid[idx]&dirty[idx], else ALLOC.
  - No request: proc_stall=0, stay in IDLE.
- WBACK:
  - Moore outputs: mem_write=1, mem_addr={tag[idx],idx}, mem_wdata=data[idx]; proc_stall=1.
  - Hold until mem_ready=1, then go to ALLOC.
- ALLOC:
  - Moore outputs: mem_read=1, mem_addr={proc_addr tag,idx}; proc_stall=1.
  - On the edge where mem_ready=1: data[idx]=mem_rdata, tag updated, valid=1, dirty=0; go to IDLE.
- Memory handshake:
  - mem_read and mem_write are never both 1.
  - mem_read/mem_write is held with a stable address/data until mem_ready is sampled.
  - mem_read/mem_write drops the cycle after mem_ready.
  - mem_ready seen in IDLE is ignored.
- Latency:
  - Hit: 0 stall cycles.
  - Clean miss, memory latency L cycles (mem_ready in the L-th ALLOC cycle): stall = L+1 cycles.
  - Dirty miss: stall = Lw+Lr+1 cycles.
- After refill, IDLE re-evaluates the held request:
  - it hits; a store then writes and sets dirty (write-allocate).
- proc_read & proc_write both 1 is illegal; the cache treats it as a write.
- Changing proc_addr while proc_stall=1 is illegal and unchecked.
- Index conflict:
  - Consecutive accesses to different tags at the same index thrash.
  - Each miss performs a full write-back (if dirty) and a refill.
- Reset mid-operation:
  - The pending request is abandoned; mem_read/mem_write drop immediately (async).
  - All lines are invalid afterwards; no write-back of dirty data.
- proc_rdata is defined only on a read hit; otherwise it shows the indexed block word (not a contract).

Test Plan:
- Reset, then proc_read addr=0x00000005 with the memory returning block {w3..w0}=0x33,0x22,0x11,0x00 after L=3:
  - proc_stall=1 for 4 cycles;
  - mem_read=1 with mem_addr=0x0000001 for 3 cycles;
  - then proc_rdata=0x11, proc_stall=0.
- Read hit to addr 0x00000006 right after the above -> proc_stall=0 same cycle, proc_rdata=0x22, mem_read=0.
- proc_write addr=0x00000004 data=0xDEADBEEF (hit) -> no stall, no memory traffic.
  - Then proc_read addr=0x00000024 (same index 1, tag 1) ->
    - mem_write=1, mem_addr=0x0000001, mem_wdata={0x33,0x22,0x11,0xDEADBEEF};
    - then mem_read=1 with mem_addr=0x0000009;
    - then hit.
- Write miss to a clean invalid line addr=0x00000010 data=0xA5A5A5A5 ->
  - refill only (no mem_write), then the store hits, dirty=1;
  - a later conflicting read to 0x00000030 triggers a write-back containing 0xA5A5A5A5 in word0.
- Assert rst_n=0 during ALLOC (mem_read=1) -> mem_read=0 and proc_stall=0 immediately.
  - A subsequent read to the previously cached address misses (all valid cleared).
- mem_ready held low for 20 cycles in WBACK -> mem_write, mem_addr and mem_wdata stay stable and proc_stall=1 throughout; no ALLOC entry until mem_ready.
